// File: rtl/reg_stage_elastic.sv
// Elastic pipeline register with valid/ready handshake, a two-entry skid
// buffer and a synchronous flush. in_ready depends only on the state register
// and the rst/flush controls, so no combinational path runs from out_ready
// back to in_ready.
module reg_stage_elastic #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;

    // Accept whenever the skid slot is free and no reset or flush is in progress.
    assign in_ready = (state != TWO) & ~flush & ~rst;
    assign in_fire  = in_valid & in_ready;
    assign out_data = main_q;

    // Occupancy FSM: moves entries between input, main and skid registers and
    // keeps out_valid/occupancy registered alongside the state.
    // NOTE: skid_q is never reset; it is written on entry to TWO and read only
    // in TWO, so its power-up contents can never reach out_data.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state     <= EMPTY;
            main_q    <= BUBBLE;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state     <= ONE;
                        main_q    <= in_data;
                        out_valid <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                ONE: begin
                    if (in_fire && out_ready) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        state     <= TWO;
                        skid_q    <= in_data;
                        occupancy <= 2'd2;
                    end else if (out_ready) begin
                        state     <= EMPTY;
                        main_q    <= BUBBLE;
                        out_valid <= 1'b0;
                        occupancy <= 2'd0;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        state     <= ONE;
                        main_q    <= skid_q;
                        occupancy <= 2'd1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    main_q    <= BUBBLE;
                    out_valid <= 1'b0;
                    occupancy <= 2'd0;
                end
            endcase
        end
    end

endmodule
